ex_mul_div: RTL and testbench

Multi-cycle RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It consumes the registered `mul_div_op`, `rdata1` and `rdata2` values that register presents. It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU results, and holds the pipeline with `stall_out` while an operation is in flight. When the operation finishes, the unit presents the 32-bit result to the EX result mux for one cycle.

---
 rtl/ex_mul_div.sv | 172 +++++++++++++++++
 tb/tb_ex_mul_div.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mul_div.sv
// rtl/ex_mul_div.sv - RV32M iterative multiply/divide unit; EX_MUL_DIV_FAST_MUL_EN selects a single-cycle multiplier
module ex_mul_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      mul_div_op_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic            flush_in,
  output logic            stall_out,
  output logic            result_valid_out,
  output logic [XLEN-1:0] result_out,
  output logic            busy_out
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, rem_q, rem_d, result_q, result_d;
  logic [63:0] prod_q, prod_d;
  logic        neg_q, neg_d, rneg_q, rneg_d, valid_q, valid_d;

  logic        op_valid, s1_neg, s2_neg, div_zero, ovf;
  logic [2:0]  f;
  logic [31:0] mag1, mag2, fast_res, fast_mul_res;

  assign op_valid = ~mul_div_op_in[3];
  assign f        = mul_div_op_in[2:0];
  assign s1_neg   = (f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd6) && rs1_in[31];
  assign s2_neg   = (f == 3'd1 || f == 3'd4 || f == 3'd6) && rs2_in[31];
  assign mag1     = s1_neg ? -rs1_in : rs1_in;
  assign mag2     = s2_neg ? -rs2_in : rs2_in;
  assign div_zero = f[2] && (rs2_in == 32'd0);
  assign ovf      = (f == 3'd4 || f == 3'd6) && (rs1_in == 32'h8000_0000) && (rs2_in == 32'hFFFF_FFFF);
  assign fast_res = div_zero ? (f[1] ? rs1_in : 32'hFFFF_FFFF) : (f[1] ? 32'd0 : 32'h8000_0000);

`ifdef EX_MUL_DIV_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
  logic [63:0] fx1, fx2, fprod;
  // Sign-extending to 64 bits keeps the low 64 product bits identical to a 33x33 signed multiply.
  assign fx1          = {{32{s1_neg}}, rs1_in};
  assign fx2          = {{32{s2_neg}}, rs2_in};
  assign fprod        = fx1 * fx2;
  assign fast_mul_res = (f == 3'd0) ? fprod[31:0] : fprod[63:32];
`else
  localparam bit FastMul = 1'b0;
  assign fast_mul_res = 32'd0;
`endif

  logic [63:0] prod_step, prod_fin;
  logic [32:0] rem_sh, diff;
  logic        qbit;
  logic [31:0] rem_step, quo_step, quo_fin, rem_fin, res_fin;

  assign prod_step = prod_q + (a_q[cnt_q[4:0]] ? ({32'd0, b_q} << cnt_q[4:0]) : 64'd0);
  assign rem_sh    = {rem_q, a_q[31]};
  assign diff      = rem_sh - {1'b0, b_q};
  assign qbit      = ~diff[32];
  assign rem_step  = qbit ? diff[31:0] : rem_sh[31:0];
  assign quo_step  = {a_q[30:0], qbit};
  assign prod_fin  = neg_q ? -prod_step : prod_step;
  assign quo_fin   = neg_q ? -quo_step : quo_step;
  assign rem_fin   = rneg_q ? -rem_step : rem_step;

  always_comb begin
    res_fin = rem_fin;
    case (op_q)
      3'd0:                 res_fin = prod_fin[31:0];
      3'd1, 3'd2, 3'd3:     res_fin = prod_fin[63:32];
      3'd4, 3'd5:           res_fin = quo_fin;
      default:              res_fin = rem_fin;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          op_d   = f;
          a_d    = mag1;
          b_d    = mag2;
          rem_d  = 32'd0;
          prod_d = 64'd0;
          neg_d  = s1_neg ^ s2_neg;
          rneg_d = s1_neg;
          cnt_d  = 6'd0;
          if (div_zero || ovf) begin
            result_d = fast_res;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end else if (FastMul && !f[2]) begin
            result_d = fast_mul_res;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 6'd1;
        if (op_q[2]) begin
          a_d   = quo_step;
          rem_d = rem_step;
        end else begin
          prod_d = prod_step;
        end
        if (cnt_q == 6'd31) begin
          result_d = res_fin;
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A flush kills the instruction wherever it is; nothing of it reaches the result.
    if (flush_in) begin
      state_d  = S_IDLE;
      cnt_d    = 6'd0;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      op_q     <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      rem_q    <= 32'd0;
      prod_q   <= 64'd0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 32'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign stall_out        = rst_n && !flush_in && ((state_q == S_IDLE && op_valid) || state_q == S_BUSY);
  assign result_valid_out = valid_q && !flush_in;
  assign result_out       = result_q;
  assign busy_out         = (state_q == S_BUSY);

endmodule

// File: tb/tb_ex_mul_div.sv
// tb/tb_ex_mul_div.sv - scoreboard bench for ex_mul_div against an arithmetic reference model
module tb_ex_mul_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mul_div_op_in;
  logic [31:0] rs1_in, rs2_in;
  logic        flush_in;
  logic        stall_out, result_valid_out, busy_out;
  logic [31:0] result_out;

  ex_mul_div #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .mul_div_op_in(mul_div_op_in), .rs1_in(rs1_in),
    .rs2_in(rs2_in), .flush_in(flush_in), .stall_out(stall_out),
    .result_valid_out(result_valid_out), .result_out(result_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] res;
    int          stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int ref_stall(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit fast_mul;
`ifdef EX_MUL_DIV_FAST_MUL_EN
    fast_mul = 1'b1;
`else
    fast_mul = 1'b0;
`endif
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (!f[2] && fast_mul) return 1;
    return 33;
  endfunction

  // Monitor: counts stall cycles of each op and checks every valid pulse against the queue head.
  int stall_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_cnt = 0;
      end else if (stall_out) begin
        stall_cnt++;
      end else begin
        if (result_valid_out) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk($sformatf("result_op%0d", e.op), result_out, e.res);
            chk($sformatf("stall_cycles_op%0d", e.op), stall_cnt, e.stall);
          end
        end
        stall_cnt = 0;
      end
    end
  end

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int n;
    mul_div_op_in = {1'b0, f};
    rs1_in = a;
    rs2_in = b;
    n = 0;
    @(negedge clk);
    while (stall_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("stall_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    mul_div_op_in = 4'hF;
  endtask

  task automatic issue_exp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input int exp_stall);
    exp_t e;
    e.op = f; e.res = exp_res; e.stall = exp_stall;
    exp_q.push_back(e);
    drive(f, a, b);
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    issue_exp(f, a, b, ref_res(f, a, b), ref_stall(f, a, b));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int mul_stall;

  initial begin
`ifdef EX_MUL_DIV_FAST_MUL_EN
    mul_stall = 1;
`else
    mul_stall = 33;
`endif
    rst_n = 1'b0; mul_div_op_in = 4'hF; rs1_in = 0; rs2_in = 0; flush_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", result_out, 32'd0);
    chk("reset_valid", {31'd0, result_valid_out}, 32'd0);
    chk("reset_busy", {31'd0, busy_out}, 32'd0);
    chk("reset_stall", {31'd0, stall_out}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue_exp(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, mul_stall);
    issue_exp(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, mul_stall);
    issue_exp(3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, mul_stall);
    issue_exp(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mul_stall);
    issue_exp(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    issue_exp(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    @(posedge clk); #1;
    issue_exp(3'd5, 32'd100, 32'd7, 32'd14, 33);
    issue_exp(3'd7, 32'd100, 32'd7, 32'd2, 33);
    issue_exp(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    issue_exp(3'd7, 32'd5, 32'd0, 32'd5, 1);
    issue_exp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    issue_exp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    issue_exp(3'd0, 32'd12345, 32'd678, 32'd8369910, mul_stall);
    issue_exp(3'd5, 32'd1000, 32'd10, 32'd100, 33);

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    // Flush in BUSY cycle 10.
    mul_div_op_in = 4'h5; rs1_in = 32'd1000; rs2_in = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    flush_in = 1'b1;
    @(negedge clk);
    chk("flush_busy_before", {31'd0, busy_out}, 32'd1);
    chk("flush_stall_drop", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    flush_in = 1'b0; mul_div_op_in = 4'hF;
    @(negedge clk);
    chk("flush_idle_busy", {31'd0, busy_out}, 32'd0);
    chk("flush_no_valid", {31'd0, result_valid_out}, 32'd0);
    repeat (40) @(posedge clk);
    #1;

    // Flush in DONE suppresses the pulse.
    mul_div_op_in = 4'h4; rs1_in = 32'd5; rs2_in = 32'd0;
    @(posedge clk); #1;
    flush_in = 1'b1;
    @(negedge clk);
    chk("done_flush_valid", {31'd0, result_valid_out}, 32'd0);
    chk("done_flush_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    flush_in = 1'b0; mul_div_op_in = 4'hF;
    repeat (3) @(posedge clk);
    #1;

    // Reset in BUSY cycle 10.
    issue(3'd0, 32'd3, 32'd5);
    mul_div_op_in = 4'h5; rs1_in = 32'd1000; rs2_in = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_stall_low", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    chk("rst_result", result_out, 32'd0);
    chk("rst_valid", {31'd0, result_valid_out}, 32'd0);
    chk("rst_busy", {31'd0, busy_out}, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    mul_div_op_in = 4'hF;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    // Back-to-back after reset.
    issue(3'd0, 32'hDEAD_BEEF, 32'h1234_5678);
    issue(3'd5, 32'hFFFF_FFF0, 32'd9);
    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
